// File: rtl/fade_sequencer.sv
// Colour-wheel fade sequencer: walks R/G/B duty values around six phases, one ramp step per prescaler tick.
// Outputs are registered; enable low freezes everything, restart returns to the reset state.
module fade_sequencer #(
   parameter int PWM_INTERVAL = 1200,
   parameter int STEP_CYCLES  = 1668,
   parameter int INC          = 1,
   localparam int W           = $clog2(PWM_INTERVAL)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         restart,
   output logic [W-1:0] r_value,
   output logic [W-1:0] g_value,
   output logic [W-1:0] b_value,
   output logic [2:0]   phase,
   output logic         wrap
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [W-1:0]  MAX_V   = W'(PWM_INTERVAL - 1);
   localparam logic [W:0]    MAX_X   = (W+1)'(PWM_INTERVAL - 1);
   localparam logic [W-1:0]  INC_V   = W'(INC);
   localparam logic [W:0]    INC_X   = (W+1)'(INC);
   localparam logic [PW-1:0] PRE_TOP = PW'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {
      PH0 = 3'd0, PH1 = 3'd1, PH2 = 3'd2, PH3 = 3'd3, PH4 = 3'd4, PH5 = 3'd5
   } phase_e;

   phase_e        phase_q;
   logic [W-1:0]  r_q, g_q, b_q;
   logic [PW-1:0] pre_q;
   logic          wrap_q;

   logic          tick;
   logic [W-1:0]  cur;
   logic [W:0]    up_sum;
   logic          ramp_up;
   logic          done_d;
   logic [W-1:0]  step_d;
   phase_e        phase_d;

   assign tick = (pre_q == PRE_TOP);

   // Even phases ramp their channel up, odd phases ramp down.
   always_comb begin
      cur = '0;
      case (phase_q)
         PH0, PH3: cur = g_q;
         PH1, PH4: cur = r_q;
         default:  cur = b_q;
      endcase
      ramp_up = ~phase_q[0];
      up_sum  = {1'b0, cur} + INC_X;
      done_d  = 1'b0;
      step_d  = cur;
      if (ramp_up) begin
         done_d = (up_sum >= MAX_X);
         step_d = done_d ? MAX_V : up_sum[W-1:0];
      end else begin
         done_d = (cur <= INC_V);
         step_d = done_d ? '0 : (cur - INC_V);
      end
      phase_d = (phase_q == PH5) ? PH0 : phase_e'(phase_q + 3'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH0;
         r_q     <= MAX_V;
         g_q     <= '0;
         b_q     <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else if (restart) begin
         phase_q <= PH0;
         r_q     <= MAX_V;
         g_q     <= '0;
         b_q     <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (enable) begin
            if (tick) begin
               pre_q <= '0;
               case (phase_q)
                  PH0, PH3: g_q <= step_d;
                  PH1, PH4: r_q <= step_d;
                  default:  b_q <= step_d;
               endcase
               if (done_d) begin
                  phase_q <= phase_d;
                  wrap_q  <= (phase_q == PH5);
               end
            end else begin
               pre_q <= pre_q + PW'(1);
            end
         end
      end
   end

   assign r_value = r_q;
   assign g_value = g_q;
   assign b_value = b_q;
   assign phase   = phase_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// Directed bench for fade_sequencer: INC=5 and INC=4 instances, PWM_INTERVAL=16, STEP_CYCLES=4.
module tb_fade_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       restart = 1'b0;
   logic [3:0] r5, g5, b5, r4, g4, b4;
   logic [2:0] ph5, ph4;
   logic       wr5, wr4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fade_sequencer #(.PWM_INTERVAL(16), .STEP_CYCLES(4), .INC(5)) u_inc5 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
      .r_value(r5), .g_value(g5), .b_value(b5), .phase(ph5), .wrap(wr5)
   );

   fade_sequencer #(.PWM_INTERVAL(16), .STEP_CYCLES(4), .INC(4)) u_inc4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
      .r_value(r4), .g_value(g4), .b_value(b4), .phase(ph4), .wrap(wr4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold reset two edges, release 1 ns after an edge; the next edge is edge 1.
   task automatic do_reset();
      rst_n   = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      step(2);
      rst_n  = 1'b1;
      enable = 1'b1;
   endtask

   task automatic check_rst5(input string tag);
      check({tag, "_ph"}, ph5, 0);
      check({tag, "_r"},  r5, 15);
      check({tag, "_g"},  g5, 0);
      check({tag, "_b"},  b5, 0);
      check({tag, "_wr"}, wr5, 0);
   endtask

   initial begin
      // Reset state and basic up-ramp / clamping
      rst_n = 1'b0;
      step(1);
      check_rst5("rst");
      check("rst_g4", g4, 0);
      do_reset();
      step(3);
      check("pre_g5_e3", g5, 0);
      step(1);
      check("up_g5_e4", g5, 5);
      check("up_g4_e4", g4, 4);
      step(4);
      check("up_g5_e8", g5, 10);
      check("up_g4_e8", g4, 8);
      step(4);
      check("up_g5_e12", g5, 15);
      check("up_ph5_e12", ph5, 1);
      check("up_r5_e12", r5, 15);
      check("up_b5_e12", b5, 0);
      check("clamp_g4_e12", g4, 12);
      check("clamp_ph4_e12", ph4, 0);
      step(4);
      check("clamp_g4_e16", g4, 15);
      check("clamp_ph4_e16", ph4, 1);
      check("dn_r5_e16", r5, 10);
      step(4);
      check("dn_r5_e20", r5, 5);
      step(4);
      check("dn_r5_e24", r5, 0);
      check("dn_ph5_e24", ph5, 2);
      step(44);
      check("wheel_ph_e68", ph5, 5);
      check("wheel_b_e68", b5, 5);
      check("wheel_wr_e68", wr5, 0);
      step(3);
      check("wheel_wr_e71", wr5, 0);
      step(1);
      check("wheel_ph_e72", ph5, 0);
      check("wheel_r_e72", r5, 15);
      check("wheel_g_e72", g5, 0);
      check("wheel_b_e72", b5, 0);
      check("wheel_wr_e72", wr5, 1);
      step(1);
      check("wheel_wr_e73", wr5, 0);

      // Enable hold: partial step is kept across the pause
      do_reset();
      step(2);
      enable = 1'b0;
      step(10);
      check("hold_g", g5, 0);
      check("hold_ph", ph5, 0);
      enable = 1'b1;
      step(1);
      check("hold_g_re1", g5, 0);
      step(1);
      check("hold_g_re2", g5, 5);
      enable = 1'b0;
      step(6);
      check("hold_frozen_g", g5, 5);
      enable = 1'b1;

      // Restart on the edge a tick is due, in P2 with B=10
      do_reset();
      step(32);
      check("rs_b_e32", b5, 10);
      check("rs_ph_e32", ph5, 2);
      step(3);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      check_rst5("rs");
      step(3);
      check("rs_pre_g3", g5, 0);
      step(1);
      check("rs_pre_g4", g5, 5);

      // Asynchronous reset between edges during P3
      do_reset();
      step(44);
      check("ar_ph_e44", ph5, 3);
      check("ar_g_e44", g5, 5);
      #2;
      rst_n = 1'b0;
      #1;
      check_rst5("ar_async");
      step(3);
      check_rst5("ar_held");
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
